// File: rtl/othello_board_engine.sv
// Othello board store with a sequential move engine (direction check, then place/flip one cell per clock).
// Optional define SCORE_COUNT_EN adds registered black_cnt/white_cnt disc counters.
module othello_board_engine #(
   parameter int unsigned BOARD_N = 8,
   parameter int unsigned COORD_W = 3,
   parameter int unsigned FLIP_W  = 6
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start_check,
   input  logic               start_place,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               side,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic [1:0]         rd_q,
   output logic               busy,
   output logic               done,
   output logic               legal,
   output logic [7:0]         dir,
   output logic [FLIP_W-1:0]  flip_cnt
`ifdef SCORE_COUNT_EN
   ,
   output logic [2*COORD_W:0] black_cnt,
   output logic [2*COORD_W:0] white_cnt
`endif
);

   localparam int unsigned IDX_W = 2 * COORD_W;
   localparam int unsigned MEM   = 1 << IDX_W;
   localparam int unsigned P_W   = COORD_W + 2;
   localparam int unsigned CNT_W = 2 * COORD_W + 1;

   typedef logic signed [P_W-1:0] pos_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK_INIT,
      S_CHK_WALK,
      S_CHK_NEXT,
      S_FLIP_WALK,
      S_DONE
   } state_t;

   function automatic logic [1:0] init_cell(input int unsigned idx);
      int unsigned cx;
      int unsigned cy;
      int unsigned h;
      cx = idx % BOARD_N;
      cy = idx / BOARD_N;
      h  = BOARD_N / 2;
      if ((cx == h-1 && cy == h-1) || (cx == h && cy == h))
         return 2'b10;
      if ((cx == h && cy == h-1) || (cx == h-1 && cy == h))
         return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] cx,
                                                 input logic [COORD_W-1:0] cy);
      return IDX_W'(cy) * IDX_W'(BOARD_N) + IDX_W'(cx);
   endfunction

   function automatic pos_t step_x(input logic [2:0] d);
      case (d)
         3'd1, 3'd2, 3'd3: step_x = pos_t'(1);
         3'd5, 3'd6, 3'd7: step_x = '1;
         default:          step_x = '0;
      endcase
   endfunction

   function automatic pos_t step_y(input logic [2:0] d);
      case (d)
         3'd3, 3'd4, 3'd5: step_y = pos_t'(1);
         3'd0, 3'd1, 3'd7: step_y = '1;
         default:          step_y = '0;
      endcase
   endfunction

   function automatic logic [2:0] low_bit(input logic [7:0] m);
      low_bit = '0;
      for (int unsigned i = 0; i < 8; i++)
         if (m[7-i]) low_bit = 3'(7-i);
   endfunction

   // Storage is padded to a power of two so out-of-range reads return empty.
   logic [1:0]         board_q [MEM];
   logic [1:0]         board_d [MEM];
   state_t             state_q, state_d;
   logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
   logic               side_q, side_d;
   logic               place_q, place_d;
   logic [7:0]         dir_q, dir_d;
   logic               legal_q, legal_d;
   logic [FLIP_W-1:0]  flip_cnt_q, flip_cnt_d;
   logic [2:0]         d_q, d_d;
   pos_t               px_q, px_d, py_q, py_d;
   logic               seen_q, seen_d;
   logic [7:0]         pend_q, pend_d;
   logic               tgt_done_q, tgt_done_d;

   logic [1:0]         own, opp, p_cell;
   logic               p_on, t_on, wr_en;
   logic [IDX_W-1:0]   p_idx, t_idx, wr_idx;
   logic [7:0]         pend_nx;

   assign own    = {1'b1, side_q};
   assign opp    = {1'b1, ~side_q};
   assign p_on   = (px_q >= 0) && (px_q < pos_t'(BOARD_N)) && (py_q >= 0) && (py_q < pos_t'(BOARD_N));
   assign t_on   = (pos_t'(tx_q) < pos_t'(BOARD_N)) && (pos_t'(ty_q) < pos_t'(BOARD_N));
   assign p_idx  = cell_idx(px_q[COORD_W-1:0], py_q[COORD_W-1:0]);
   assign t_idx  = cell_idx(tx_q, ty_q);
   assign p_cell = p_on ? board_q[p_idx] : 2'b00;

   assign rd_q     = board_q[cell_idx(rd_x, rd_y)];
   assign busy     = (state_q != S_IDLE);
   assign legal    = legal_q;
   assign dir      = dir_q;
   assign flip_cnt = flip_cnt_q;

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      ty_d       = ty_q;
      side_d     = side_q;
      place_d    = place_q;
      dir_d      = dir_q;
      legal_d    = legal_q;
      flip_cnt_d = flip_cnt_q;
      d_d        = d_q;
      px_d       = px_q;
      py_d       = py_q;
      seen_d     = seen_q;
      pend_d     = pend_q;
      tgt_done_d = tgt_done_q;
      board_d    = board_q;
      wr_en      = 1'b0;
      wr_idx     = p_idx;
      done       = 1'b0;
      pend_nx    = pend_q & ~(8'b1 << d_q);

      case (state_q)
         S_IDLE: begin
            if (start_check || start_place) begin
               tx_d       = x;
               ty_d       = y;
               side_d     = side;
               place_d    = start_place;
               dir_d      = '0;
               legal_d    = 1'b0;
               flip_cnt_d = '0;
               state_d    = S_CHK_INIT;
            end
         end
         S_CHK_INIT: begin
            if (!t_on || board_q[t_idx][1]) begin
               state_d = S_DONE;
            end else begin
               d_d     = '0;
               px_d    = pos_t'(tx_q) + step_x(3'd0);
               py_d    = pos_t'(ty_q) + step_y(3'd0);
               seen_d  = 1'b0;
               state_d = S_CHK_WALK;
            end
         end
         S_CHK_WALK: begin
            if (!p_on || !p_cell[1] || (p_cell == own && !seen_q)) begin
               state_d = S_CHK_NEXT;
            end else if (p_cell == own) begin
               dir_d[d_q] = 1'b1;
               state_d    = S_CHK_NEXT;
            end else begin
               seen_d = 1'b1;
               px_d   = px_q + step_x(d_q);
               py_d   = py_q + step_y(d_q);
            end
         end
         S_CHK_NEXT: begin
            if (d_q == 3'd7) begin
               legal_d    = |dir_q;
               tgt_done_d = 1'b0;
               state_d    = (place_q && dir_q != '0) ? S_FLIP_WALK : S_DONE;
            end else begin
               d_d     = d_q + 3'd1;
               px_d    = pos_t'(tx_q) + step_x(d_q + 3'd1);
               py_d    = pos_t'(ty_q) + step_y(d_q + 3'd1);
               seen_d  = 1'b0;
               state_d = S_CHK_WALK;
            end
         end
         S_FLIP_WALK: begin
            // Target first, then each latched direction in ascending order; an own-colour
            // cell retires the direction and costs one cycle without a write.
            if (!tgt_done_q) begin
               wr_en      = 1'b1;
               wr_idx     = t_idx;
               tgt_done_d = 1'b1;
               pend_d     = dir_q;
               d_d        = low_bit(dir_q);
               px_d       = pos_t'(tx_q) + step_x(low_bit(dir_q));
               py_d       = pos_t'(ty_q) + step_y(low_bit(dir_q));
            end else if (p_on && p_cell == opp) begin
               wr_en      = 1'b1;
               flip_cnt_d = flip_cnt_q + FLIP_W'(1);
               px_d       = px_q + step_x(d_q);
               py_d       = py_q + step_y(d_q);
            end else begin
               pend_d = pend_nx;
               if (pend_nx == '0) begin
                  state_d = S_DONE;
               end else begin
                  d_d  = low_bit(pend_nx);
                  px_d = pos_t'(tx_q) + step_x(low_bit(pend_nx));
                  py_d = pos_t'(ty_q) + step_y(low_bit(pend_nx));
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_en)
         board_d[wr_idx] = own;
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q    <= S_IDLE;
         tx_q       <= '0;
         ty_q       <= '0;
         side_q     <= 1'b0;
         place_q    <= 1'b0;
         dir_q      <= '0;
         legal_q    <= 1'b0;
         flip_cnt_q <= '0;
         d_q        <= '0;
         px_q       <= '0;
         py_q       <= '0;
         seen_q     <= 1'b0;
         pend_q     <= '0;
         tgt_done_q <= 1'b0;
         for (int unsigned i = 0; i < MEM; i++)
            board_q[i] <= init_cell(i);
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         side_q     <= side_d;
         place_q    <= place_d;
         dir_q      <= dir_d;
         legal_q    <= legal_d;
         flip_cnt_q <= flip_cnt_d;
         d_q        <= d_d;
         px_q       <= px_d;
         py_q       <= py_d;
         seen_q     <= seen_d;
         pend_q     <= pend_d;
         tgt_done_q <= tgt_done_d;
         board_q    <= board_d;
      end
   end

`ifdef SCORE_COUNT_EN
   logic [CNT_W-1:0] black_cnt_q, black_cnt_d, white_cnt_q, white_cnt_d;

   // Every write gains one disc for the mover; writes after the target also take one from the opponent.
   always_comb begin
      black_cnt_d = black_cnt_q;
      white_cnt_d = white_cnt_q;
      if (wr_en) begin
         if (side_q) begin
            black_cnt_d = black_cnt_q + CNT_W'(1);
            if (tgt_done_q) white_cnt_d = white_cnt_q - CNT_W'(1);
         end else begin
            white_cnt_d = white_cnt_q + CNT_W'(1);
            if (tgt_done_q) black_cnt_d = black_cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         black_cnt_q <= CNT_W'(2);
         white_cnt_q <= CNT_W'(2);
      end else begin
         black_cnt_q <= black_cnt_d;
         white_cnt_q <= white_cnt_d;
      end
   end

   assign black_cnt = black_cnt_q;
   assign white_cnt = white_cnt_q;
`endif

endmodule

// File: tb/tb_othello_board_engine.sv
// Bench for othello_board_engine: directed cases plus random play against a rule-level board model.
module tb_othello_board_engine;

   localparam int N = 8;

   logic       clock = 1'b0;
   logic       resetn = 1'b1;
   logic       start_check = 1'b0;
   logic       start_place = 1'b0;
   logic [2:0] x = '0, y = '0, rd_x = '0, rd_y = '0;
   logic       side = 1'b0;
   logic [1:0] rd_q;
   logic       busy, done, legal;
   logic [7:0] dir;
   logic [5:0] flip_cnt;
`ifdef SCORE_COUNT_EN
   logic [6:0] black_cnt, white_cnt;
`endif

   othello_board_engine #(.BOARD_N(8), .COORD_W(3), .FLIP_W(6)) dut (
      .clock(clock), .resetn(resetn), .start_check(start_check), .start_place(start_place),
      .x(x), .y(y), .side(side), .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q),
      .busy(busy), .done(done), .legal(legal), .dir(dir), .flip_cnt(flip_cnt)
`ifdef SCORE_COUNT_EN
      , .black_cnt(black_cnt), .white_cnt(white_cnt)
`endif
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   logic [1:0] bm [N][N];
   int DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
   int DY [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit on_b(input int cx, input int cy);
      return cx >= 0 && cx < N && cy >= 0 && cy < N;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            bm[i][j] = 2'b00;
      bm[N/2-1][N/2-1] = 2'b10;
      bm[N/2][N/2]     = 2'b10;
      bm[N/2][N/2-1]   = 2'b11;
      bm[N/2-1][N/2]   = 2'b11;
   endfunction

   function automatic logic [7:0] model_dirs(input int tx, input int ty, input bit s);
      logic [7:0] m;
      logic [1:0] own, opp;
      m   = '0;
      own = s ? 2'b11 : 2'b10;
      opp = s ? 2'b10 : 2'b11;
      if (bm[tx][ty][1]) return '0;
      for (int d = 0; d < 8; d++) begin
         int cx, cy, n;
         cx = tx + DX[d];
         cy = ty + DY[d];
         n  = 0;
         while (on_b(cx, cy) && bm[cx][cy] == opp) begin
            n++;
            cx += DX[d];
            cy += DY[d];
         end
         if (n > 0 && on_b(cx, cy) && bm[cx][cy] == own) m[d] = 1'b1;
      end
      return m;
   endfunction

   function automatic int model_place(input int tx, input int ty, input bit s);
      logic [7:0] m;
      logic [1:0] own;
      int flips;
      m     = model_dirs(tx, ty, s);
      own   = s ? 2'b11 : 2'b10;
      flips = 0;
      if (m == '0) return 0;
      bm[tx][ty] = own;
      for (int d = 0; d < 8; d++) begin
         if (m[d]) begin
            int cx, cy;
            cx = tx + DX[d];
            cy = ty + DY[d];
            while (bm[cx][cy] != own) begin
               bm[cx][cy] = own;
               flips++;
               cx += DX[d];
               cy += DY[d];
            end
         end
      end
      return flips;
   endfunction

   function automatic int model_count(input logic [1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (bm[i][j] == v) c++;
      return c;
   endfunction

   task automatic compare_board(input string tag);
      int nmis, fx, fy;
      nmis = 0;
      fx = 0;
      fy = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            rd_x = 3'(i);
            rd_y = 3'(j);
            #1;
            if (rd_q !== bm[i][j]) begin
               if (nmis == 0) begin fx = i; fy = j; end
               nmis++;
            end
         end
      end
      if (nmis != 0) $display("board %s first differing cell (%0d,%0d)", tag, fx, fy);
      check(tag, nmis, 0);
   endtask

   task automatic reset_dut();
      @(negedge clock);
      resetn = 1'b1;
      start_check = 1'b0;
      start_place = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b0;
      model_reset();
   endtask

   task automatic do_cmd(input bit place, input bit both, input int cx, input int cy, input bit s);
      logic [7:0] ed;
      int ef, lat, bound;
      bit seen;
      ed = model_dirs(cx, cy, s);
      ef = place ? model_place(cx, cy, s) : 0;
      @(negedge clock);
      x = 3'(cx);
      y = 3'(cy);
      side = s;
      start_place = place;
      start_check = !place || both;
      @(negedge clock);
      start_place = 1'b0;
      start_check = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (lat < 400 && !seen) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge clock);
            lat++;
         end
      end
      check("done_seen", seen, 1);
      check("dir", dir, ed);
      check("legal", legal, |ed);
      check("flip_cnt", flip_cnt, ef);
      bound = 2 + 8 * N;
      if (place && ed != '0) bound += 1 + ef + $countones(ed);
      check("latency_within_bound", lat <= bound, 1);
`ifdef SCORE_COUNT_EN
      check("black_cnt", black_cnt, model_count(2'b11));
      check("white_cnt", white_cnt, model_count(2'b10));
`endif
      @(negedge clock);
      check("done_one_cycle", done, 0);
      check("busy_released", busy, 0);
      compare_board("board_after_cmd");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int any_busy, any_done, seen_wr, cur;
      int q[$];

      // Reset state
      reset_dut();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_legal", legal, 0);
      check("reset_dir", dir, 0);
      check("reset_flip_cnt", flip_cnt, 0);
      compare_board("reset_board");

      // Opening moves from the reset position
      do_cmd(1'b0, 1'b0, 2, 3, 1'b1);
      check("check_2_3_dir_const", dir, 8'h04);
      do_cmd(1'b1, 1'b0, 2, 3, 1'b1);
      check("place_2_3_flip_const", flip_cnt, 1);
      rd_x = 3'd3; rd_y = 3'd3; #1;
      check("place_2_3_cell_3_3", rd_q, 2'b11);
`ifdef SCORE_COUNT_EN
      check("place_2_3_black_const", black_cnt, 4);
      check("place_2_3_white_const", white_cnt, 1);
`endif
      do_cmd(1'b0, 1'b0, 3, 3, 1'b0);
      do_cmd(1'b0, 1'b0, 0, 0, 1'b1);
      do_cmd(1'b1, 1'b0, 0, 0, 1'b1);
      check("place_0_0_legal_const", legal, 0);

      // Both starts high: place wins
      reset_dut();
      do_cmd(1'b1, 1'b1, 2, 3, 1'b1);

      // Start pulsed while busy is ignored
      reset_dut();
      @(negedge clock);
      x = 3'd2; y = 3'd3; side = 1'b1; start_check = 1'b1;
      @(negedge clock);
      start_check = 1'b0;
      @(negedge clock);
      x = 3'd3; y = 3'd2; start_place = 1'b1;
      @(negedge clock);
      start_place = 1'b0;
      any_done = 0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin any_done = 1; break; end
         @(negedge clock);
      end
      check("busy_start_done", any_done, 1);
      check("busy_start_dir", dir, 8'h04);
      check("busy_start_flip", flip_cnt, 0);
      any_busy = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (busy) any_busy = 1;
      end
      check("busy_start_ignored", any_busy, 0);
      compare_board("busy_start_board");

      // Reset during the flip phase aborts without a done pulse
      reset_dut();
      rd_x = 3'd2; rd_y = 3'd3;
      @(negedge clock);
      x = 3'd2; y = 3'd3; side = 1'b1; start_place = 1'b1;
      @(negedge clock);
      start_place = 1'b0;
      seen_wr = 0;
      any_done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done) any_done = 1;
         if (rd_q == 2'b11) begin seen_wr = 1; break; end
      end
      check("flip_phase_reached", seen_wr, 1);
      check("no_done_before_flip", any_done, 0);
      resetn = 1'b1;
      @(negedge clock);
      resetn = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_flip_cnt", flip_cnt, 0);
      any_done = done;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (done || busy) any_done = 1;
      end
      check("abort_no_done", any_done, 0);
      model_reset();
      compare_board("abort_board");

      // Random play against the model
      reset_dut();
      cur = 1;
      for (int step = 0; step < 120; step++) begin
         int r, mv;
         q.delete();
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (model_dirs(i, j, cur[0]) != '0) q.push_back(i * N + j);
         if (q.size() == 0) begin
            cur = 1 - cur;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  if (model_dirs(i, j, cur[0]) != '0) q.push_back(i * N + j);
         end
         if (q.size() == 0) begin
            reset_dut();
            cur = 1;
            continue;
         end
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            do_cmd(1'b0, 1'b0, int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)), 1'($urandom));
         end else if (r < 3) begin
            do_cmd(1'b1, 1'b0, int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)), 1'($urandom));
         end else begin
            mv = q[$urandom_range(0, q.size() - 1)];
            do_cmd(1'b1, (r == 9), mv / N, mv % N, cur[0]);
            cur = 1 - cur;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
